// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller.
// Holds FSM state encodings, direction codes and PS/2 scancodes.
package game_pkg;

  typedef enum logic [1:0] {
    ST_COVER = 2'd0,
    ST_GAME  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [1:0] DIR_L    = 2'b10;
  localparam logic [1:0] DIR_R    = 2'b01;
  localparam logic [1:0] DIR_NONE = 2'b00;

  localparam logic [8:0] KC_ENTER    = 9'h05A;
  localparam logic [8:0] KC_KP_ENTER = 9'h15A;
  localparam logic [8:0] KC_PAUSE    = 9'h04D;
  localparam logic [8:0] KC_ESC      = 9'h076;
  localparam logic [8:0] KC_P0_L     = 9'h01C;
  localparam logic [8:0] KC_P0_R     = 9'h023;
  localparam logic [8:0] KC_P1_L     = 9'h16B;
  localparam logic [8:0] KC_P1_R     = 9'h174;

  // True on a press event of the given scancode.
  function automatic logic key_press(
    input logic       vld,
    input logic       make,
    input logic [8:0] code,
    input logic [8:0] ref_code
  );
    return vld & make & (code == ref_code);
  endfunction

endpackage

// File: rtl/key_hold_dir.sv
// Per-player held-key tracker for one left/right key pair.
// Emits the direction the tracker will hold after this cycle.
module key_hold_dir
  import game_pkg::*;
#(
  parameter logic [8:0] L_CODE = KC_P0_L,
  parameter logic [8:0] R_CODE = KC_P0_R
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [8:0] key_code,
  input  logic       key_make,
  output logic [1:0] dir_nxt
);

  logic held_l_q, held_l_d;
  logic held_r_q, held_r_d;
  logic last_r_q, last_r_d;

  // Update held flags on make/break; remember the latest press.
  always_comb begin
    held_l_d = held_l_q;
    held_r_d = held_r_q;
    last_r_d = last_r_q;
    if (key_valid && key_code == L_CODE) begin
      held_l_d = key_make;
      if (key_make) last_r_d = 1'b0;
    end
    if (key_valid && key_code == R_CODE) begin
      held_r_d = key_make;
      if (key_make) last_r_d = 1'b1;
    end
  end

  // Resolve direction; with both held the latest press wins.
  always_comb begin
    dir_nxt = DIR_NONE;
    unique case ({held_l_d, held_r_d})
      2'b10:   dir_nxt = DIR_L;
      2'b01:   dir_nxt = DIR_R;
      2'b11:   dir_nxt = last_r_d ? DIR_R : DIR_L;
      default: dir_nxt = DIR_NONE;
    endcase
  end

  // Held-state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      held_l_q <= 1'b0;
      held_r_q <= 1'b0;
      last_r_q <= 1'b0;
    end else begin
      held_l_q <= held_l_d;
      held_r_q <= held_r_d;
      last_r_q <= last_r_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: COVER/GAME/PAUSE/OVER FSM with timed OVER
// screen, alive mask and gated per-player direction outputs.
module game_ctrl
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int OVER_TICKS  = 50_000_000,
  parameter int TMR_W       = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [8:0]               key_code,
  input  logic                     key_make,
  input  logic [NUM_PLAYERS-1:0]   die,
  output logic [1:0]               game_state,
  output logic                     game_rst,
  output logic                     run_en,
  output logic [2*NUM_PLAYERS-1:0] dir,
  output logic [NUM_PLAYERS-1:0]   alive
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OVER_TICKS - 1);
  localparam logic [NUM_PLAYERS-1:0] ALL_ALIVE = '1;

  state_e                   state_q, state_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic [NUM_PLAYERS-1:0]   alive_q, alive_d;
  logic                     grst_q, grst_d;
  logic                     run_q, run_d;
  logic [2*NUM_PLAYERS-1:0] dir_q, dir_d;
  logic [2*NUM_PLAYERS-1:0] raw_dir;
  logic                     mk_enter, mk_pause, mk_esc;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_ply
    localparam logic [8:0] LC = (g == 0) ? KC_P0_L : KC_P1_L;
    localparam logic [8:0] RC = (g == 0) ? KC_P0_R : KC_P1_R;
    key_hold_dir #(
      .L_CODE(LC),
      .R_CODE(RC)
    ) u_khd (
      .clk      (clk),
      .rst      (rst),
      .key_valid(key_valid),
      .key_code (key_code),
      .key_make (key_make),
      .dir_nxt  (raw_dir[2*g +: 2])
    );
  end

  assign mk_enter =
    key_press(key_valid, key_make, key_code, KC_ENTER) |
    key_press(key_valid, key_make, key_code, KC_KP_ENTER);
  assign mk_pause =
    key_press(key_valid, key_make, key_code, KC_PAUSE);
  assign mk_esc =
    key_press(key_valid, key_make, key_code, KC_ESC);

  // Next state, alive mask, OVER timer and start pulse.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    alive_d = alive_q;
    grst_d  = 1'b0;
    unique case (state_q)
      ST_COVER: begin
        if (mk_enter) begin
          state_d = ST_GAME;
          grst_d  = 1'b1;
          alive_d = ALL_ALIVE;
        end
      end
      ST_GAME: begin
        alive_d = alive_q & ~die;
        if (alive_d == '0) begin
          state_d = ST_OVER;
          tmr_d   = '0;
        end else if (mk_pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (mk_pause)    state_d = ST_GAME;
        else if (mk_esc) state_d = ST_COVER;
      end
      ST_OVER: begin
        if (tmr_q == TMR_LAST) begin
          state_d = ST_COVER;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = ST_COVER;
    endcase
  end

  // Gate directions: only live players in GAME may move.
  always_comb begin
    dir_d = '0;
    run_d = (state_d == ST_GAME);
    if (run_d) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (alive_d[i]) dir_d[2*i +: 2] = raw_dir[2*i +: 2];
      end
    end
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_COVER;
      tmr_q   <= '0;
      alive_q <= ALL_ALIVE;
      grst_q  <= 1'b0;
      run_q   <= 1'b0;
      dir_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      alive_q <= alive_d;
      grst_q  <= grst_d;
      run_q   <= run_d;
      dir_q   <= dir_d;
    end
  end

  assign game_state = state_q;
  assign game_rst   = grst_q;
  assign run_en     = run_q;
  assign dir        = dir_q;
  assign alive      = alive_q;

endmodule
